wb_stage: RTL

- Final pipeline stage of the scalar core. Sits directly upstream of the register file's write port.
- Accepts one instruction per cycle from the memory stage over a valid/allowin handshake and holds it in a pipeline register.
- Sign/zero-extends load data by byte lane, then drives the register file write port.
- Also drives the forwarding bus back to decode and the retire trace port.

---
 rtl/wb_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: final (write-back) stage of the scalar core.
// Holds one instruction from the memory stage in a pipeline register,
// extends load data by byte lane and drives the register file write port,
// the forwarding bus back to decode and the retire trace port.
//
// Ports:
//   clk, reset (sync, active-low)
//   ms_to_ws_valid / ws_allowin  : handshake with the memory stage
//   ms_pc, ms_gr_we, ms_dest, ms_result, ms_ld_op, ms_addr_lo : offered payload
//   wb_hold                      : external freeze, blocks retirement
//   rf_we, rf_waddr, rf_wdata    : register file write port
//   ws_fwd_valid/dest/data       : forwarding bus to decode
//   debug_wb_*                   : retire trace
module wb_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  input  logic [2:0]  ms_ld_op,
  input  logic [1:0]  ms_addr_lo,
  input  logic        wb_hold,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_fwd_valid,
  output logic [4:0]  ws_fwd_dest,
  output logic [31:0] ws_fwd_data,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  logic            ws_valid;
  logic [XLEN-1:0] pc;
  logic            gr_we;
  logic [RW-1:0]   dest;
  logic [XLEN-1:0] result;
  logic [2:0]      ld_op;
  logic [1:0]      addr_lo;

  logic            ws_ready_go;
  logic            retire;
  logic            writes_reg;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ext_data;

  assign ws_ready_go = !wb_hold;
  assign ws_allowin  = !ws_valid || ws_ready_go;

  // Valid bit and payload pipeline register; payload keeps stale values on bubbles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ws_valid <= 1'b0;
      pc       <= PC_RESET;
      gr_we    <= 1'b0;
      dest     <= '0;
      result   <= '0;
      ld_op    <= '0;
      addr_lo  <= '0;
    end else begin
      if (ws_allowin) begin
        ws_valid <= ms_to_ws_valid;
      end
      if (ms_to_ws_valid && ws_allowin) begin
        pc      <= ms_pc;
        gr_we   <= ms_gr_we;
        dest    <= ms_dest;
        result  <= ms_result;
        ld_op   <= ms_ld_op;
        addr_lo <= ms_addr_lo;
      end
    end
  end

  // Byte/halfword lane select and sign/zero extension of load data.
  always_comb begin
    ld_byte  = 8'h00;
    ld_half  = addr_lo[1] ? result[31:16] : result[15:0];
    ext_data = result;
    case (addr_lo)
      2'd0:    ld_byte = result[7:0];
      2'd1:    ld_byte = result[15:8];
      2'd2:    ld_byte = result[23:16];
      default: ld_byte = result[31:24];
    endcase
    case (ld_op)
      LD_LB:   ext_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ext_data = {24'h000000, ld_byte};
      LD_LH:   ext_data = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ext_data = {16'h0000, ld_half};
      default: ext_data = result;
    endcase
  end

  // Register 0 is never written, neither directly nor via forwarding.
  assign writes_reg = ws_valid && gr_we && (dest != '0);
  assign retire     = ws_valid && ws_ready_go;

  assign rf_we    = retire && writes_reg;
  assign rf_waddr = ws_valid ? dest : '0;
  assign rf_wdata = ws_valid ? ext_data : '0;

  // Forwarded data is final even while held, so forwarding ignores wb_hold.
  assign ws_fwd_valid = writes_reg;
  assign ws_fwd_dest  = rf_waddr;
  assign ws_fwd_data  = rf_wdata;

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule
